// File: rtl/conv_1d_mac_array.sv
// Multi-channel 1-D convolution MAC: accumulates KLEN signed w*x taps per channel and presents one result window.
// Optional output clamping is compiled in with `define CONV1D_MAC_SAT_EN; otherwise results wrap to OUT_W bits.
//
// state | meaning
// ------+-------------------------------------------------------
// ACC   | accepting tap beats, accumulating per-channel sums
// HOLD  | result window presented, waiting for out_ready
module conv_1d_mac_array #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 8,
  parameter int KLEN   = 3,
  parameter int OUT_W  = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [NUM_CH*DATA_W-1:0]   w_in,
  input  logic [NUM_CH*DATA_W-1:0]   x_in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [NUM_CH*OUT_W-1:0]    out_data,
  output logic [NUM_CH-1:0]          sat_flag,
  output logic [$clog2(KLEN):0]      tap_cnt
);

  localparam int CLOG_K = (KLEN > 1) ? $clog2(KLEN) : 1;
  localparam int ACC_W  = 2*DATA_W + CLOG_K;
  localparam int PROD_W = 2*DATA_W;
  localparam int TCW    = $clog2(KLEN) + 1;

  typedef enum logic {S_ACC = 1'b0, S_HOLD = 1'b1} state_t;

  state_t state_q, state_d;

  logic signed [ACC_W-1:0]   acc_q [NUM_CH];
  logic signed [ACC_W-1:0]   sum_d [NUM_CH];
  logic [NUM_CH*OUT_W-1:0]   conv_d;
  logic                      fire;
  logic                      tap_last;

  assign fire     = in_valid & in_ready;
  assign tap_last = (tap_cnt == TCW'(KLEN-1));

`ifdef CONV1D_MAC_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
  logic [NUM_CH-1:0] sat_d;
  logic [NUM_CH-1:0] sat_q;
`endif

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic signed [DATA_W-1:0] w_c;
    logic signed [DATA_W-1:0] x_c;
    logic signed [PROD_W-1:0] prod_c;
    logic signed [ACC_W-1:0]  prod_ext;

    assign w_c      = w_in[c*DATA_W +: DATA_W];
    assign x_c      = x_in[c*DATA_W +: DATA_W];
    assign prod_c   = w_c * x_c;
    assign prod_ext = {{(ACC_W-PROD_W){prod_c[PROD_W-1]}}, prod_c};
    assign sum_d[c] = acc_q[c] + prod_ext;

`ifdef CONV1D_MAC_SAT_EN
    logic sat_hi;
    logic sat_lo;
    assign sat_hi   = (sum_d[c] > SAT_MAX);
    assign sat_lo   = (sum_d[c] < SAT_MIN);
    assign sat_d[c] = sat_hi | sat_lo;
    assign conv_d[c*OUT_W +: OUT_W] = sat_hi ? SAT_MAX[OUT_W-1:0] :
                                      sat_lo ? SAT_MIN[OUT_W-1:0] :
                                               sum_d[c][OUT_W-1:0];
`else
    assign conv_d[c*OUT_W +: OUT_W] = sum_d[c][OUT_W-1:0];
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_ACC;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = S_ACC;
    end else begin
      case (state_q)
        S_ACC:   if (fire && tap_last) state_d = S_HOLD;
        S_HOLD:  if (out_ready)        state_d = S_ACC;
        default: state_d = S_ACC;
      endcase
    end
  end

  // Handshake outputs come straight from the state so out_ready never reaches in_ready.
  always_comb begin
    in_ready  = (state_q == S_ACC);
    out_valid = (state_q == S_HOLD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CH; c++) acc_q[c] <= '0;
      tap_cnt  <= '0;
      out_data <= '0;
    end else if (clear) begin
      for (int c = 0; c < NUM_CH; c++) acc_q[c] <= '0;
      tap_cnt <= '0;
    end else if (fire) begin
      if (tap_last) begin
        for (int c = 0; c < NUM_CH; c++) acc_q[c] <= '0;
        tap_cnt  <= '0;
        out_data <= conv_d;
      end else begin
        for (int c = 0; c < NUM_CH; c++) acc_q[c] <= sum_d[c];
        tap_cnt <= tap_cnt + TCW'(1);
      end
    end
  end

`ifdef CONV1D_MAC_SAT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 sat_q <= '0;
    else if (clear)             sat_q <= '0;
    else if (fire && tap_last)  sat_q <= sat_d;
  end

  assign sat_flag = sat_q;
`else
  assign sat_flag = '0;
`endif

endmodule

// File: tb/tb_conv_1d_mac_array.sv
// Directed self-checking bench for conv_1d_mac_array: default instance plus a NUM_CH=1/KLEN=1/DATA_W=4 instance.
// Expected values follow CONV1D_MAC_SAT_EN when the bench is built with it.
module tb_conv_1d_mac_array;

  localparam int NUM_CH = 4;
  localparam int DATA_W = 8;
  localparam int OUT_W  = 16;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic                     clear = 1'b0;
  logic                     in_valid = 1'b0;
  logic                     out_ready = 1'b0;
  logic [NUM_CH*DATA_W-1:0] w_in = '0;
  logic [NUM_CH*DATA_W-1:0] x_in = '0;
  logic                     in_ready;
  logic                     out_valid;
  logic [NUM_CH*OUT_W-1:0]  out_data;
  logic [NUM_CH-1:0]        sat_flag;
  logic [2:0]               tap_cnt;

  logic       s_clear = 1'b0;
  logic       s_in_valid = 1'b0;
  logic       s_out_ready = 1'b0;
  logic [3:0] s_w = '0;
  logic [3:0] s_x = '0;
  logic       s_in_ready;
  logic       s_out_valid;
  logic [7:0] s_out_data;
  logic [0:0] s_sat;
  logic [0:0] s_tap_cnt;

  int checks = 0;
  int failures = 0;

  conv_1d_mac_array #(.NUM_CH(4), .DATA_W(8), .KLEN(3), .OUT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .w_in(w_in), .x_in(x_in), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .sat_flag(sat_flag), .tap_cnt(tap_cnt)
  );

  conv_1d_mac_array #(.NUM_CH(1), .DATA_W(4), .KLEN(1), .OUT_W(8)) dut_k1 (
    .clk(clk), .rst_n(rst_n), .clear(s_clear), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .w_in(s_w), .x_in(s_x), .out_valid(s_out_valid), .out_ready(s_out_ready),
    .out_data(s_out_data), .sat_flag(s_sat), .tap_cnt(s_tap_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NUM_CH*DATA_W-1:0] rep8(input logic [7:0] v);
    logic [NUM_CH*DATA_W-1:0] r;
    for (int c = 0; c < NUM_CH; c++) r[c*DATA_W +: DATA_W] = v;
    return r;
  endfunction

  function automatic logic [NUM_CH*OUT_W-1:0] rep16(input logic [15:0] v);
    logic [NUM_CH*OUT_W-1:0] r;
    for (int c = 0; c < NUM_CH; c++) r[c*OUT_W +: OUT_W] = v;
    return r;
  endfunction

  task automatic set_taps(input logic [7:0] w, input logic [7:0] x);
    w_in = rep8(w);
    x_in = rep8(x);
  endtask

  task automatic run_window(input logic [7:0] w, input logic [7:0] x);
    in_valid = 1'b1;
    set_taps(w, x);
    repeat (3) tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks++;
    if (out_valid !== 1'b0 || tap_cnt !== 3'd0 || out_data !== '0 || sat_flag !== '0) begin
      failures++;
      $display("FAIL reset_outputs got valid=%0b cnt=%0d data=%0h sat=%0h exp all zero",
               out_valid, tap_cnt, out_data, sat_flag);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (in_ready !== 1'b1 || s_in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready got=%0b/%0b exp=1/1", in_ready, s_in_ready);
    end
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    set_taps(8'd1, 8'd4);
    tick();
    checks++;
    if (tap_cnt !== 3'd1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL basic_tap1 got cnt=%0d valid=%0b exp cnt=1 valid=0", tap_cnt, out_valid);
    end
    set_taps(8'd2, 8'd5);
    tick();
    checks++;
    if (tap_cnt !== 3'd2 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL basic_tap2 got cnt=%0d valid=%0b exp cnt=2 valid=0", tap_cnt, out_valid);
    end
    set_taps(8'd3, 8'd6);
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== rep16(16'd32) || tap_cnt !== 3'd0) begin
      failures++;
      $display("FAIL basic_result got valid=%0b rdy=%0b data=%0h cnt=%0d exp 1 0 %0h 0",
               out_valid, in_ready, out_data, tap_cnt, rep16(16'd32));
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL basic_release got valid=%0b rdy=%0b exp 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_saturation();
    logic [NUM_CH*OUT_W-1:0] exp_data;
    logic [NUM_CH-1:0]       exp_sat;
`ifdef CONV1D_MAC_SAT_EN
    exp_data = {16'd3, 16'd3, 16'd3, 16'h7FFF};
    exp_sat  = 4'b0001;
`else
    exp_data = {16'd3, 16'd3, 16'd3, 16'hC000};
    exp_sat  = 4'b0000;
`endif
    out_ready = 1'b1;
    in_valid  = 1'b1;
    w_in = {8'd1, 8'd1, 8'd1, 8'h80};
    x_in = {8'd1, 8'd1, 8'd1, 8'h80};
    repeat (3) tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== exp_data || sat_flag !== exp_sat) begin
      failures++;
      $display("FAIL sat_result got valid=%0b data=%0h sat=%0b exp 1 %0h %0b",
               out_valid, out_data, sat_flag, exp_data, exp_sat);
    end
    tick();
  endtask

  task automatic test_hold();
    out_ready = 1'b0;
    run_window(8'd2, 8'd3);
    in_valid = 1'b1;
    set_taps(8'd7, 8'd7);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== rep16(16'd18) || tap_cnt !== 3'd0) begin
        failures++;
        $display("FAIL hold_stable cyc=%0d got valid=%0b rdy=%0b data=%0h cnt=%0d exp 1 0 %0h 0",
                 i, out_valid, in_ready, out_data, tap_cnt, rep16(16'd18));
      end
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || tap_cnt !== 3'd0) begin
      failures++;
      $display("FAIL hold_release got valid=%0b rdy=%0b cnt=%0d exp 0 1 0", out_valid, in_ready, tap_cnt);
    end
    run_window(8'd1, 8'd1);
    checks++;
    if (out_valid !== 1'b1 || out_data !== rep16(16'd3)) begin
      failures++;
      $display("FAIL hold_no_accum got valid=%0b data=%0h exp 1 %0h", out_valid, out_data, rep16(16'd3));
    end
    tick();
  endtask

  task automatic test_clear();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    set_taps(8'd5, 8'd5);
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checks++;
    if (tap_cnt !== 3'd0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL clear_tap got cnt=%0d valid=%0b exp 0 0", tap_cnt, out_valid);
    end
    set_taps(8'd1, 8'd1);
    tick();
    tick();
    checks++;
    if (tap_cnt !== 3'd2 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL clear_resume got cnt=%0d valid=%0b exp 2 0", tap_cnt, out_valid);
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== rep16(16'd3)) begin
      failures++;
      $display("FAIL clear_result got valid=%0b data=%0h exp 1 %0h", out_valid, out_data, rep16(16'd3));
    end
    out_ready = 1'b0;
    tick();
    clear = 1'b1;
    out_ready = 1'b1;
    tick();
    clear = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || sat_flag !== '0) begin
      failures++;
      $display("FAIL clear_hold got valid=%0b rdy=%0b sat=%0b exp 0 1 0", out_valid, in_ready, sat_flag);
    end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    set_taps(8'd9, 8'd9);
    tick();
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (tap_cnt !== 3'd0 || out_valid !== 1'b0 || out_data !== '0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL arst_window got cnt=%0d valid=%0b data=%0h rdy=%0b exp 0 0 0 1",
               tap_cnt, out_valid, out_data, in_ready);
    end
    #1 rst_n = 1'b1;
    run_window(8'd1, 8'd1);
    checks++;
    if (out_valid !== 1'b1 || out_data !== rep16(16'd3)) begin
      failures++;
      $display("FAIL arst_no_partial got valid=%0b data=%0h exp 1 %0h", out_valid, out_data, rep16(16'd3));
    end
    tick();
    out_ready = 1'b0;
    run_window(8'd2, 8'd3);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || sat_flag !== '0) begin
      failures++;
      $display("FAIL arst_hold got valid=%0b data=%0h sat=%0b exp 0 0 0", out_valid, out_data, sat_flag);
    end
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    tick();
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL arst_no_stale got valid=%0b data=%0h rdy=%0b exp 0 0 1", out_valid, out_data, in_ready);
    end
  endtask

  task automatic test_klen1();
    int results;
    results     = 0;
    s_out_ready = 1'b1;
    s_in_valid  = 1'b1;
    s_w         = 4'h8;
    s_x         = 4'h7;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (s_out_valid !== ((i % 2) == 0) || s_in_ready !== ((i % 2) != 0)) begin
        failures++;
        $display("FAIL k1_alternate cyc=%0d got valid=%0b rdy=%0b exp valid=%0b",
                 i, s_out_valid, s_in_ready, ((i % 2) == 0));
      end
      if (s_out_valid === 1'b1) begin
        results++;
        checks++;
        if (s_out_data !== 8'hC8 || s_sat !== 1'b0) begin
          failures++;
          $display("FAIL k1_data cyc=%0d got data=%0h sat=%0b exp c8 0", i, s_out_data, s_sat);
        end
      end
    end
    s_in_valid = 1'b0;
    checks++;
    if (results != 3) begin
      failures++;
      $display("FAIL k1_count got=%0d exp=3", results);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_hold();
    test_clear();
    test_async_reset();
    test_klen1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
